vram_write_sequencer: RTL and testbench
=======================================

// Module: vram_write_sequencer
// PURPOSE
//  Sequences CPU pixel writes into the single-port VideoMemory and shares its row/column port with the VGA scan.
//  CPU writes row/column cursor registers and pixel data; data writes auto-increment the cursor.
//  Pending writes queue in a FIFO. The FIFO drains into VideoMemory only while the VGA is blanking.
//  Sits between the CPU bus and VideoMemory inside the GPU; VGA address passes through during active display.
// PARAMETERS
//  NUM_ROWS    120  rows in VideoMemory; row cursor wraps at NUM_ROWS-1
//  NUM_COLS    160  columns in VideoMemory; column cursor wraps at NUM_COLS-1
//  FIFO_DEPTH  8    pending-write entries (power of 2, >=2); each entry is {row[7:0],col[7:0],data[7:0]}
// PORTS
//  clk         in   1  system clock; everything, including vga_active, is synchronous to it
//  rst_n       in   1  asynchronous active-low reset
//  cpu_we      in   1  CPU write strobe, one write per cycle high
//  cpu_sel     in   2  register select: 0=ROW 1=COL 2=DATA 3=CTRL
//  cpu_din     in   8  CPU write data
//  cpu_full    out  1  FIFO full; DATA writes dropped while high
//  ovf         out  1  sticky: a DATA write was dropped
//  fill_busy   out  1  screen fill in progress (tied 0 without VRAM_FILL_EN)
//  vga_active  in   1  VGA in visible region; VideoMemory port owned by VGA
//  vga_row     in   8  VGA read row
//  vga_col     in   8  VGA read column
//  vm_we       out  1  VideoMemory write enable
//  vm_row      out  8  VideoMemory row
//  vm_col      out  8  VideoMemory column
//  vm_din      out  8  VideoMemory write data
// BEHAVIOUR
//  Reset: cursors=0, FIFO empty, state IDLE; cpu_full=0, ovf=0, fill_busy=0, vm_we=0, vm_row/vm_col/vm_din=0.
//  ROW/COL write: loads the cursor next cycle. Values >= NUM_ROWS or >= NUM_COLS load 0.
//  DATA write, FIFO not full:
//    - pushes {row,col,din}.
//    - col++; at NUM_COLS-1, col wraps to 0 and row++; at NUM_ROWS-1, row wraps to 0.
//  DATA write, FIFO full: the write is dropped, the cursor is unchanged, and ovf is set.
//    Fullness is sampled before the cycle; a pop in the same cycle does not admit the push.
//  CTRL write: din[0]=1 clears ovf. A clear and a new drop in the same cycle leave ovf set.
//  Port ownership:
//    - vga_active=1: vm_row/vm_col = vga_row/vga_col (combinational), vm_we=0, no pop.
//    - vga_active=0: the sequencer owns the port and may write one entry per cycle.
//  States:
//    - IDLE -> DRAIN when the FIFO is non-empty and vga_active=0.
//    - DRAIN: pop the head and drive it on vm_* with vm_we=1 the same cycle.
//    - DRAIN -> IDLE when the FIFO empties or vga_active=1.
//    - An entry is popped only when vm_we=1. If vga_active rises, no write occurs and the entry is retained.
//  Latency: a DATA write accepted in cycle N reaches vm_we at cycle N+1 at the earliest (blanking).
//  Order: VideoMemory writes occur in exact CPU write order.
//  Simultaneous push and pop are legal when not full; count is unchanged.
//  Async reset mid-drain or mid-fill: the FIFO is discarded and pending writes are lost.
// CONFIGURATION
//  VRAM_FILL_EN defined:
//    - CTRL din[1]=1 starts a fill with colour {5'b0,din[4:2]}; state FILL, fill_busy=1.
//    - Each blanking cycle writes one cell, row-major from (0,0) to (NUM_ROWS-1,NUM_COLS-1).
//    - FILL -> IDLE after the last cell; fill_busy falls the following cycle.
//    - FILL has priority over DRAIN. CPU DATA writes still queue during a fill and drain after it.
//    - Start while fill_busy=1 is ignored.
//  VRAM_FILL_EN undefined: din[1] and din[4:2] are ignored, no FILL state, fill_busy tied 0.
// STRUCTURE
//  video_pkg: register-select constants (SEL_ROW/SEL_COL/SEL_DATA/SEL_CTRL), CTRL bit positions,
//    state encoding (ST_IDLE/ST_DRAIN/ST_FILL), entry field widths.
//  Sub-module vram_wr_fifo:
//    - synchronous FIFO, async active-low reset, push/pop/full/empty, count.
//    - First-word fall-through head. Parameterised by FIFO_DEPTH and width.
//  Top: cursor logic, state machine, fill counters, port mux.
// TESTING
//  1 ROW=5, COL=158, DATA 0x11,0x22,0x33, vga_active=0
//    -> vm writes (5,158,0x11), (5,159,0x22), (6,0,0x33) on consecutive cycles.
//  2 vga_active=1, 9 DATA writes with FIFO_DEPTH=8
//    -> cpu_full after the 8th, 9th dropped, ovf=1, vm_we stays 0.
//    -> Then blanking: exactly 8 writes in order; CTRL 0x01 clears ovf.
//  3 Cursor at (119,159), DATA 0x44 -> written at (119,159); next DATA lands at (0,0).
//  4 Drain of 4 entries, vga_active rises after 2 writes
//    -> vm_row/vm_col follow vga_row/vga_col, vm_we=0; remaining 2 are written at the next blanking.
//  5 VRAM_FILL_EN: CTRL 0x0E (colour 3), continuous blanking
//    -> 19200 writes of 0x03, fill_busy high throughout.
//    -> A DATA write queued mid-fill lands after the last fill write.
//  6 rst_n low mid-drain -> all outputs 0 immediately (async); after release, the FIFO is empty and there are no writes.

Source files
------------

// File: rtl/vram_write_sequencer_pkg.sv
// vram_write_sequencer_pkg
// Shared definitions for the VRAM write sequencer:
//   - CPU register-select codes (SEL_ROW/SEL_COL/SEL_DATA/SEL_CTRL)
//   - CTRL register bit positions
//   - sequencer state encoding (ST_IDLE/ST_DRAIN/ST_FILL)
//   - pending-write entry layout and field widths
//   - clamp_coord(): loads out-of-range cursor values as 0
package vram_write_sequencer_pkg;

  localparam int ROW_W   = 8;
  localparam int COL_W   = 8;
  localparam int DATA_W  = 8;
  localparam int ENTRY_W = ROW_W + COL_W + DATA_W;

  localparam logic [1:0] SEL_ROW  = 2'd0;
  localparam logic [1:0] SEL_COL  = 2'd1;
  localparam logic [1:0] SEL_DATA = 2'd2;
  localparam logic [1:0] SEL_CTRL = 2'd3;

  localparam int CTRL_OVF_CLR_BIT = 0;
  localparam int CTRL_FILL_BIT    = 1;
  localparam int CTRL_COLOUR_LSB  = 2;
  localparam int CTRL_COLOUR_MSB  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FILL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [DATA_W-1:0] data;
  } entry_t;

  // A cursor register only ever holds a legal coordinate; anything at or
  // beyond the limit is loaded as 0.
  function automatic logic [7:0] clamp_coord(input logic [7:0] value,
                                             input int unsigned limit);
    return (32'(value) >= limit) ? 8'd0 : value;
  endfunction

endpackage

// File: rtl/vram_write_sequencer_if.sv
// vram_write_sequencer_if
// Bundles the CPU register bus, the VGA scan address and the VideoMemory
// port of the write sequencer.
//   master: CPU/VGA side (drives cpu_*, vga_*; observes status and vm_*)
//   slave : the sequencer (drives cpu_full, ovf, fill_busy, vm_*)
interface vram_write_sequencer_if;
  import vram_write_sequencer_pkg::*;

  logic              cpu_we;
  logic [1:0]        cpu_sel;
  logic [DATA_W-1:0] cpu_din;
  logic              cpu_full;
  logic              ovf;
  logic              fill_busy;
  logic              vga_active;
  logic [ROW_W-1:0]  vga_row;
  logic [COL_W-1:0]  vga_col;
  logic              vm_we;
  logic [ROW_W-1:0]  vm_row;
  logic [COL_W-1:0]  vm_col;
  logic [DATA_W-1:0] vm_din;

  modport master (
    output cpu_we, cpu_sel, cpu_din, vga_active, vga_row, vga_col,
    input  cpu_full, ovf, fill_busy, vm_we, vm_row, vm_col, vm_din
  );

  modport slave (
    input  cpu_we, cpu_sel, cpu_din, vga_active, vga_row, vga_col,
    output cpu_full, ovf, fill_busy, vm_we, vm_row, vm_col, vm_din
  );

endinterface

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo
// Synchronous first-word-fall-through FIFO holding pending pixel writes.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (contents discarded)
//   push/push_data  write an entry (ignored while full)
//   pop             consume the head (ignored while empty)
//   head            current head entry, valid whenever empty=0
//   full/empty      occupancy flags
//   count           number of stored entries
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module vram_wr_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

endmodule

// File: rtl/vram_write_sequencer.sv
// vram_write_sequencer
// Queues CPU pixel writes and drains them into the single-port VideoMemory
// while the VGA scan is blanking; during active display the VGA address
// passes straight through to the memory port.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  cpu_we/cpu_sel/cpu_din register writes, cpu_full/ovf/fill_busy
//                status, vga_active/vga_row/vga_col scan address,
//                vm_we/vm_row/vm_col/vm_din VideoMemory port
// Configuration:
//   VRAM_FILL_EN  when defined, CTRL bit 1 starts a whole-screen fill with the
//                 colour in CTRL bits 4:2; otherwise those bits are ignored and
//                 fill_busy is tied 0.
module vram_write_sequencer
  import vram_write_sequencer_pkg::*;
#(
  parameter int unsigned NUM_ROWS   = 120,
  parameter int unsigned NUM_COLS   = 160,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vram_write_sequencer_if.slave  bus
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q;
  state_e            state_d;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic              ovf_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  entry_t            fifo_head;
  entry_t            push_entry;

  logic              data_wr;
  logic              data_push;
  logic              data_drop;
  logic              ctrl_wr;
  logic              drain_we;

  logic              fill_start;
  logic              fill_we;
  logic              fill_last;
  logic [ROW_W-1:0]  fill_row;
  logic [COL_W-1:0]  fill_col;
  logic [DATA_W-1:0] fill_data;

  assign data_wr    = bus.cpu_we && (bus.cpu_sel == SEL_DATA);
  assign data_push  = data_wr && !fifo_full;
  assign data_drop  = data_wr && fifo_full;
  assign ctrl_wr    = bus.cpu_we && (bus.cpu_sel == SEL_CTRL);
  assign push_entry = '{row: row_q, col: col_q, data: bus.cpu_din};

  assign bus.cpu_full = fifo_full;
  assign bus.ovf      = ovf_q;

  vram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (data_push),
    .push_data (push_entry),
    .pop       (drain_we),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Cursor registers. A DATA write only advances the cursor when the entry
  // was actually accepted, so a dropped write leaves the cursor in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else if (bus.cpu_we) begin
      case (bus.cpu_sel)
        SEL_ROW: row_q <= clamp_coord(bus.cpu_din, NUM_ROWS);
        SEL_COL: col_q <= clamp_coord(bus.cpu_din, NUM_COLS);
        SEL_DATA: begin
          if (!fifo_full) begin
            if (col_q == COL_LAST) begin
              col_q <= '0;
              row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky overflow flag; a drop always wins over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (data_drop) begin
      ovf_q <= 1'b1;
    end else if (ctrl_wr && bus.cpu_din[CTRL_OVF_CLR_BIT]) begin
      ovf_q <= 1'b0;
    end
  end

`ifdef VRAM_FILL_EN
  logic [ROW_W-1:0] fill_row_q;
  logic [COL_W-1:0] fill_col_q;
  logic [2:0]       fill_colour_q;

  assign fill_start    = ctrl_wr && bus.cpu_din[CTRL_FILL_BIT] && (state_q != ST_FILL);
  assign fill_we       = (state_q == ST_FILL) && !bus.vga_active;
  assign fill_last     = (fill_row_q == ROW_LAST) && (fill_col_q == COL_LAST);
  assign fill_row      = fill_row_q;
  assign fill_col      = fill_col_q;
  assign fill_data     = {5'b0, fill_colour_q};
  assign bus.fill_busy = (state_q == ST_FILL);

  // Fill cursor walks the screen row-major, advancing only on blanking
  // cycles where a cell was actually written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_row_q    <= '0;
      fill_col_q    <= '0;
      fill_colour_q <= '0;
    end else if (fill_start) begin
      fill_row_q    <= '0;
      fill_col_q    <= '0;
      fill_colour_q <= bus.cpu_din[CTRL_COLOUR_MSB:CTRL_COLOUR_LSB];
    end else if (fill_we) begin
      if (fill_col_q == COL_LAST) begin
        fill_col_q <= '0;
        fill_row_q <= fill_last ? '0 : fill_row_q + 1'b1;
      end else begin
        fill_col_q <= fill_col_q + 1'b1;
      end
    end
  end
`else
  assign fill_start    = 1'b0;
  assign fill_we       = 1'b0;
  assign fill_last     = 1'b0;
  assign fill_row      = '0;
  assign fill_col      = '0;
  assign fill_data     = '0;
  assign bus.fill_busy = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and drain strobe. The drain write is issued in the same cycle
  // the FSM decides to drain, so an entry pushed in cycle N can be written in
  // cycle N+1. DRAIN is held only while entries will remain after this pop.
  always_comb begin
    state_d  = state_q;
    drain_we = 1'b0;
    case (state_q)
      ST_IDLE, ST_DRAIN: begin
        drain_we = !fifo_empty && !bus.vga_active;
        if (fill_start) begin
          state_d = ST_FILL;
        end else if (drain_we && !((fifo_count == CNT_W'(1)) && !data_push)) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (fill_we && fill_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory port mux: the VGA scan owns the port during active display;
  // otherwise a fill cell or the FIFO head is presented with vm_we.
  always_comb begin
    bus.vm_we  = 1'b0;
    bus.vm_row = '0;
    bus.vm_col = '0;
    bus.vm_din = '0;
    if (bus.vga_active) begin
      bus.vm_row = bus.vga_row;
      bus.vm_col = bus.vga_col;
    end else if (fill_we) begin
      bus.vm_we  = 1'b1;
      bus.vm_row = fill_row;
      bus.vm_col = fill_col;
      bus.vm_din = fill_data;
    end else if (drain_we) begin
      bus.vm_we  = 1'b1;
      bus.vm_row = fifo_head.row;
      bus.vm_col = fifo_head.col;
      bus.vm_din = fifo_head.data;
    end
  end

endmodule

// File: tb/tb_vram_write_sequencer.sv
// tb_vram_write_sequencer
// Self-checking bench for vram_write_sequencer. Each stimulus cycle updates a
// behavioural model (cursor, pending-entry count, overflow, fill progress)
// and pushes expected VideoMemory writes into a queue; a monitor on the
// falling edge compares status outputs and pops the queue on every vm_we.
// The fill scenario is exercised only when VRAM_FILL_EN is defined.
module tb_vram_write_sequencer;
  import vram_write_sequencer_pkg::*;

  localparam int NUM_ROWS   = 120;
  localparam int NUM_COLS   = 160;
  localparam int FIFO_DEPTH = 8;

  logic clk;
  logic rst_n;

  vram_write_sequencer_if bus();

  vram_write_sequencer #(
    .NUM_ROWS   (NUM_ROWS),
    .NUM_COLS   (NUM_COLS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model state
  int m_row;
  int m_col;
  int pend_cnt;
  int fill_left;
  bit m_ovf;
  logic [23:0] exp_q [$];

  // Expectations for the current cycle, read by the monitor
  bit mon_en;
  bit exp_full;
  bit exp_ovf;
  bit exp_busy;
  bit exp_we;
  bit exp_va;
  logic [7:0] exp_vr;
  logic [7:0] exp_vc;
  logic [23:0] mon_entry;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    m_row = 0; m_col = 0; pend_cnt = 0; fill_left = 0; m_ovf = 0;
    exp_q.delete();
    exp_full = 0; exp_ovf = 0; exp_busy = 0; exp_we = 0;
    exp_va = 0; exp_vr = 0; exp_vc = 0;
  endtask

  // Drive one cycle of inputs and advance the model by that cycle.
  task automatic applyStimulus(input logic we, input logic [1:0] sel, input logic [7:0] din,
                               input logic va, input logic [7:0] vr, input logic [7:0] vc);
    bit fill_wr;
    bit pop;
    @(posedge clk);
    #1;
    bus.cpu_we = we; bus.cpu_sel = sel; bus.cpu_din = din;
    bus.vga_active = va; bus.vga_row = vr; bus.vga_col = vc;

    exp_full = (pend_cnt == FIFO_DEPTH);
    exp_ovf  = m_ovf;
    exp_busy = (fill_left > 0);
    exp_va = va; exp_vr = vr; exp_vc = vc;
    fill_wr = exp_busy && !va;
    pop     = !exp_busy && !va && (pend_cnt > 0);
    exp_we  = fill_wr || pop;

    if (pop) pend_cnt--;
    if (fill_wr) fill_left--;
    if (we) begin
      case (sel)
        SEL_ROW: m_row = (int'(din) >= NUM_ROWS) ? 0 : int'(din);
        SEL_COL: m_col = (int'(din) >= NUM_COLS) ? 0 : int'(din);
        SEL_DATA: begin
          if (exp_full) begin
            m_ovf = 1;
          end else begin
            exp_q.push_back({m_row[7:0], m_col[7:0], din});
            pend_cnt++;
            m_col++;
            if (m_col == NUM_COLS) begin
              m_col = 0;
              m_row = (m_row + 1) % NUM_ROWS;
            end
          end
        end
        default: begin
          if (din[0]) m_ovf = 0;
`ifdef VRAM_FILL_EN
          if (din[1] && !exp_busy) begin
            fill_left = NUM_ROWS * NUM_COLS;
            for (int i = 0; i < NUM_ROWS * NUM_COLS; i++) begin
              exp_q.push_back({8'(i / NUM_COLS), 8'(i % NUM_COLS), 5'b0, din[4:2]});
            end
          end
`endif
        end
      endcase
    end
  endtask

  task automatic idleCycles(input int n, input logic va);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, SEL_ROW, 8'h00, va, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
  endtask

  task automatic writeReg(input logic [1:0] sel, input logic [7:0] din, input logic va);
    applyStimulus(1'b1, sel, din, va, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  // Monitor: status every cycle, passthrough during display, scoreboard on writes.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("cpu_full", 32'(bus.cpu_full), 32'(exp_full));
      checkOutput("ovf", 32'(bus.ovf), 32'(exp_ovf));
      checkOutput("fill_busy", 32'(bus.fill_busy), 32'(exp_busy));
      checkOutput("vm_we", 32'(bus.vm_we), 32'(exp_we));
      if (exp_va) begin
        checkOutput("vm_row_pass", 32'(bus.vm_row), 32'(exp_vr));
        checkOutput("vm_col_pass", 32'(bus.vm_col), 32'(exp_vc));
      end else if (bus.vm_we) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write", 32'(1), 32'(0));
        end else begin
          mon_entry = exp_q.pop_front();
          checkOutput("vm_row", 32'(bus.vm_row), 32'(mon_entry[23:16]));
          checkOutput("vm_col", 32'(bus.vm_col), 32'(mon_entry[15:8]));
          checkOutput("vm_din", 32'(bus.vm_din), 32'(mon_entry[7:0]));
        end
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_vm_we"}, 32'(bus.vm_we), 32'(0));
    checkOutput({tag, "_vm_row"}, 32'(bus.vm_row), 32'(0));
    checkOutput({tag, "_vm_col"}, 32'(bus.vm_col), 32'(0));
    checkOutput({tag, "_vm_din"}, 32'(bus.vm_din), 32'(0));
    checkOutput({tag, "_cpu_full"}, 32'(bus.cpu_full), 32'(0));
    checkOutput({tag, "_ovf"}, 32'(bus.ovf), 32'(0));
    checkOutput({tag, "_fill_busy"}, 32'(bus.fill_busy), 32'(0));
  endtask

  initial begin
    int va_state;
    int r;
    checks = 0;
    failures = 0;
    mon_en = 0;
    resetModel();
    rst_n = 1'b0;
    bus.cpu_we = 0; bus.cpu_sel = SEL_ROW; bus.cpu_din = 0;
    bus.vga_active = 0; bus.vga_row = 0; bus.vga_col = 0;
    #3;
    checkAllZero("reset");
    #9;
    rst_n = 1'b1;
    mon_en = 1;

    $display("[TB] cursor wrap within a row, continuous blanking");
    writeReg(SEL_ROW, 8'd5, 1'b0);
    writeReg(SEL_COL, 8'd158, 1'b0);
    writeReg(SEL_DATA, 8'h11, 1'b0);
    writeReg(SEL_DATA, 8'h22, 1'b0);
    writeReg(SEL_DATA, 8'h33, 1'b0);
    idleCycles(4, 1'b0);

    $display("[TB] overflow during active display");
    for (int i = 0; i < 9; i++) writeReg(SEL_DATA, 8'(8'hA0 + i), 1'b1);
    idleCycles(2, 1'b1);
    idleCycles(10, 1'b0);
    writeReg(SEL_CTRL, 8'h01, 1'b0);
    idleCycles(2, 1'b0);

    $display("[TB] last cell wraps to origin");
    writeReg(SEL_ROW, 8'd119, 1'b0);
    writeReg(SEL_COL, 8'd159, 1'b0);
    writeReg(SEL_DATA, 8'h44, 1'b0);
    writeReg(SEL_DATA, 8'h55, 1'b0);
    writeReg(SEL_ROW, 8'd200, 1'b0);
    writeReg(SEL_COL, 8'd170, 1'b0);
    writeReg(SEL_DATA, 8'h66, 1'b0);
    idleCycles(3, 1'b0);

    $display("[TB] drain interrupted by active display");
    for (int i = 0; i < 4; i++) writeReg(SEL_DATA, 8'(8'hC0 + i), 1'b1);
    idleCycles(2, 1'b0);
    idleCycles(3, 1'b1);
    idleCycles(4, 1'b0);

    $display("[TB] async reset mid-drain");
    for (int i = 0; i < 4; i++) writeReg(SEL_DATA, 8'(8'hD0 + i), 1'b1);
    applyStimulus(1'b0, SEL_ROW, 8'h00, 1'b0, 8'h00, 8'h00);
    #2;
    checkOutput("pre_reset_vm_we", 32'(bus.vm_we), 32'(1));
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    resetModel();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    mon_en = 1;
    idleCycles(4, 1'b0);
    writeReg(SEL_DATA, 8'h5A, 1'b0);
    idleCycles(2, 1'b0);

    $display("[TB] randomized traffic");
    va_state = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] din;
      logic [1:0] sel;
      if ($urandom_range(0, 7) == 0) va_state = 1 - va_state;
      r = int'($urandom_range(0, 9));
      sel = (r < 6) ? SEL_DATA : (r == 6) ? SEL_ROW : (r == 7) ? SEL_COL : SEL_CTRL;
      din = 8'($urandom_range(0, 255));
      if (sel == SEL_CTRL) din[1] = 1'b0;
      applyStimulus(1'($urandom_range(0, 9) < 7), sel, din, 1'(va_state),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    idleCycles(20, 1'b0);

`ifdef VRAM_FILL_EN
    $display("[TB] screen fill");
    writeReg(SEL_CTRL, 8'h0E, 1'b0);
    for (int i = 0; i < NUM_ROWS * NUM_COLS + 10; i++) begin
      if (i == 100) writeReg(SEL_DATA, 8'h7E, 1'b0);
      else if (i == 200) writeReg(SEL_CTRL, 8'h1E, 1'b0);
      else idleCycles(1, 1'b0);
    end
    idleCycles(5, 1'b0);
`endif

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
